// File: rtl/sap_control_sequencer_if.sv
// Control/status bundle between the SAP sequencer (master) and the datapath (slave).
interface sap_control_sequencer_if;
  logic       run;
  logic [3:0] opcode;
  logic       alu_carry, alu_zero;
  logic       pc_out, pc_inc, jump;
  logic       mar_in, ram_in, ram_out;
  logic       ir_in, ir_out;
  logic       a_in, a_out, b_in, b_out;
  logic       alu_out, subtract;
  logic       out_in;
  logic [2:0] step;
  logic       halted;

  modport master (
    input  run, opcode, alu_carry, alu_zero,
    output pc_out, pc_inc, jump, mar_in, ram_in, ram_out, ir_in, ir_out,
           a_in, a_out, b_in, b_out, alu_out, subtract, out_in, step, halted
  );

  modport slave (
    output run, opcode, alu_carry, alu_zero,
    input  pc_out, pc_inc, jump, mar_in, ram_in, ram_out, ir_in, ir_out,
           a_in, a_out, b_in, b_out, alu_out, subtract, out_in, step, halted
  );
endinterface

// File: rtl/sap_control_sequencer.sv
// SAP-1 style T-state control sequencer: fetch T0/T1, opcode-decoded execute T2..T4, sticky halt.
// Define JUMP_FLAGS_EN to add carry/zero flag registers and the JC (0x7) / JZ (0x8) opcodes.
module sap_control_sequencer #(
  parameter int              OP_W       = 4,
  parameter logic [OP_W-1:0] HLT_OPCODE = 4'hF,
  parameter logic [OP_W-1:0] OUT_OPCODE = 4'hE
) (
  input logic                  clock,
  input logic                  reset,
  sap_control_sequencer_if.master bus
);

  typedef enum logic [2:0] {T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4} step_t;

  step_t           step_q, step_d;
  logic            halted_q, halted_d;
  logic [OP_W-1:0] op;
  logic            is_hlt, is_out;

  logic pc_out_c, pc_inc_c, jump_c, mar_in_c, ram_in_c, ram_out_c, ir_in_c, ir_out_c;
  logic a_in_c, a_out_c, b_in_c, b_out_c, alu_out_c, subtract_c, out_in_c;

  assign op     = bus.opcode;
  assign is_hlt = (op == HLT_OPCODE);
  assign is_out = (op == OUT_OPCODE) && !is_hlt;

`ifdef JUMP_FLAGS_EN
  logic carry_f, zero_f, flag_ld;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      carry_f <= 1'b0;
      zero_f  <= 1'b0;
    end else if (flag_ld) begin
      carry_f <= bus.alu_carry;
      zero_f  <= bus.alu_zero;
    end
  end
`else
  logic unused_alu_flags;
  assign unused_alu_flags = bus.alu_carry ^ bus.alu_zero;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    step_d     = step_q;
    halted_d   = halted_q;
    pc_out_c   = 1'b0; pc_inc_c  = 1'b0; jump_c    = 1'b0;
    mar_in_c   = 1'b0; ram_in_c  = 1'b0; ram_out_c = 1'b0;
    ir_in_c    = 1'b0; ir_out_c  = 1'b0;
    a_in_c     = 1'b0; a_out_c   = 1'b0; b_in_c    = 1'b0; b_out_c = 1'b0;
    alu_out_c  = 1'b0; subtract_c = 1'b0; out_in_c = 1'b0;
`ifdef JUMP_FLAGS_EN
    flag_ld    = 1'b0;
`endif
    if (halted_q) begin
      step_d = T0;
    end else begin
      unique case (step_q)
        T0: begin
          // run only gates the start of an instruction; idle otherwise
          if (bus.run) begin
            pc_out_c = 1'b1; mar_in_c = 1'b1;
            step_d   = T1;
          end
        end
        T1: begin
          ram_out_c = 1'b1; ir_in_c = 1'b1; pc_inc_c = 1'b1;
          step_d    = T2;
        end
        T2: begin
          step_d = T0;
          if (is_hlt) begin
            halted_d = 1'b1;
          end else if (is_out) begin
            a_out_c = 1'b1; out_in_c = 1'b1;
          end else begin
            case (op)
              4'h1, 4'h2, 4'h3, 4'h4: begin
                ir_out_c = 1'b1; mar_in_c = 1'b1;
                step_d   = T3;
              end
              4'h5: begin ir_out_c = 1'b1; a_in_c = 1'b1; end
              4'h6: begin ir_out_c = 1'b1; jump_c = 1'b1; end
`ifdef JUMP_FLAGS_EN
              4'h7: begin ir_out_c = 1'b1; jump_c = carry_f; end
              4'h8: begin ir_out_c = 1'b1; jump_c = zero_f;  end
`endif
              default: ;
            endcase
          end
        end
        T3: begin
          step_d = T0;
          case (op)
            4'h1:       begin ram_out_c = 1'b1; a_in_c = 1'b1; end
            4'h2, 4'h3: begin ram_out_c = 1'b1; b_in_c = 1'b1; step_d = T4; end
            4'h4:       begin a_out_c = 1'b1; ram_in_c = 1'b1; end
            default: ;
          endcase
        end
        T4: begin
          alu_out_c  = 1'b1; a_in_c = 1'b1;
          subtract_c = (op == 4'h3);
`ifdef JUMP_FLAGS_EN
          flag_ld    = 1'b1;
`endif
          step_d     = T0;
        end
        default: step_d = T0;
      endcase
    end
  end

  // reset masks strobes immediately, not just after the step register clears
  assign bus.pc_out   = pc_out_c   & ~reset;
  assign bus.pc_inc   = pc_inc_c   & ~reset;
  assign bus.jump     = jump_c     & ~reset;
  assign bus.mar_in   = mar_in_c   & ~reset;
  assign bus.ram_in   = ram_in_c   & ~reset;
  assign bus.ram_out  = ram_out_c  & ~reset;
  assign bus.ir_in    = ir_in_c    & ~reset;
  assign bus.ir_out   = ir_out_c   & ~reset;
  assign bus.a_in     = a_in_c     & ~reset;
  assign bus.a_out    = a_out_c    & ~reset;
  assign bus.b_in     = b_in_c     & ~reset;
  assign bus.b_out    = b_out_c    & ~reset;
  assign bus.alu_out  = alu_out_c  & ~reset;
  assign bus.subtract = subtract_c & ~reset;
  assign bus.out_in   = out_in_c   & ~reset;
  assign bus.step     = step_q;
  assign bus.halted   = halted_q;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Scoreboard bench for sap_control_sequencer: microprogram-table model feeds expected words, monitor compares.
module tb_sap_control_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b1;

  sap_control_sequencer_if bus();
  sap_control_sequencer dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  // control word bit order: pc_out pc_inc jump mar_in ram_in ram_out ir_in ir_out a_in a_out b_in b_out alu_out subtract out_in
  localparam logic [14:0] PC_OUT = 15'h4000, PC_INC = 15'h2000, JUMP = 15'h1000, MAR_IN = 15'h0800;
  localparam logic [14:0] RAM_IN = 15'h0400, RAM_OUT = 15'h0200, IR_IN = 15'h0100, IR_OUT = 15'h0080;
  localparam logic [14:0] A_IN = 15'h0040, A_OUT = 15'h0020, B_IN = 15'h0010, B_OUT = 15'h0008;
  localparam logic [14:0] ALU_OUT = 15'h0004, SUBTRACT = 15'h0002, OUT_IN = 15'h0001;
  localparam logic [14:0] DRIVERS = PC_OUT | RAM_OUT | IR_OUT | A_OUT | B_OUT | ALU_OUT;

  typedef struct {
    logic [2:0]  step;
    logic [14:0] ctl;
    logic        halted;
    bit          hlt_after;
    bit          latch;
  } word_t;

  word_t      pend[$];
  word_t      sb[$];
  logic [3:0] plan[$];
  logic [3:0] cur_op = 4'h0;
  bit         m_halted = 0, m_c = 0, m_z = 0;
  bit         fix_alu = 0, fix_c = 0, fix_z = 0;
  int         checks = 0, errors = 0;

  function automatic word_t mk(input logic [2:0] s, input logic [14:0] c,
                               input bit h = 0, input bit l = 0);
    word_t w;
    w.step = s; w.ctl = c; w.halted = 1'b0; w.hlt_after = h; w.latch = l;
    return w;
  endfunction

  // Whole-instruction expansion from the opcode table.
  function automatic void build(input logic [3:0] op);
    pend.push_back(mk(3'd0, PC_OUT | MAR_IN));
    pend.push_back(mk(3'd1, RAM_OUT | IR_IN | PC_INC));
    case (op)
      4'hF: pend.push_back(mk(3'd2, 15'd0, 1));
      4'hE: pend.push_back(mk(3'd2, A_OUT | OUT_IN));
      4'h1: begin
        pend.push_back(mk(3'd2, IR_OUT | MAR_IN));
        pend.push_back(mk(3'd3, RAM_OUT | A_IN));
      end
      4'h2, 4'h3: begin
        pend.push_back(mk(3'd2, IR_OUT | MAR_IN));
        pend.push_back(mk(3'd3, RAM_OUT | B_IN));
        pend.push_back(mk(3'd4, ALU_OUT | A_IN | ((op == 4'h3) ? SUBTRACT : 15'd0), 0, 1));
      end
      4'h4: begin
        pend.push_back(mk(3'd2, IR_OUT | MAR_IN));
        pend.push_back(mk(3'd3, A_OUT | RAM_IN));
      end
      4'h5: pend.push_back(mk(3'd2, IR_OUT | A_IN));
      4'h6: pend.push_back(mk(3'd2, IR_OUT | JUMP));
`ifdef JUMP_FLAGS_EN
      4'h7: pend.push_back(mk(3'd2, IR_OUT | (m_c ? JUMP : 15'd0)));
      4'h8: pend.push_back(mk(3'd2, IR_OUT | (m_z ? JUMP : 15'd0)));
`endif
      default: pend.push_back(mk(3'd2, 15'd0));
    endcase
  endfunction

  task automatic cyc(input logic r, input logic rs);
    word_t w;
    @(posedge clock); #1;
    reset         = rs;
    bus.run       = r;
    bus.alu_carry = fix_alu ? fix_c : 1'($urandom);
    bus.alu_zero  = fix_alu ? fix_z : 1'($urandom);
    bus.opcode    = 4'($urandom);
    if (rs) begin
      pend.delete();
      m_halted = 0; m_c = 0; m_z = 0;
      w = mk(3'd0, 15'd0);
    end else if (m_halted) begin
      w = mk(3'd0, 15'd0);
      w.halted = 1'b1;
    end else begin
      if (pend.size() == 0 && r) begin
        cur_op = (plan.size() > 0) ? plan.pop_front() : 4'($urandom);
        build(cur_op);
      end
      if (pend.size() == 0) begin
        w = mk(3'd0, 15'd0);
      end else begin
        w = pend.pop_front();
        if (w.hlt_after) m_halted = 1;
        if (w.latch) begin m_c = bus.alu_carry; m_z = bus.alu_zero; end
      end
      if (w.step >= 3'd2) bus.opcode = cur_op;
    end
    sb.push_back(w);
  endtask

  task automatic chk(input string nm, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h want %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    word_t       w;
    logic [14:0] act;
    if (sb.size() > 0) begin
      w   = sb.pop_front();
      act = {bus.pc_out, bus.pc_inc, bus.jump, bus.mar_in, bus.ram_in, bus.ram_out, bus.ir_in,
             bus.ir_out, bus.a_in, bus.a_out, bus.b_in, bus.b_out, bus.alu_out, bus.subtract,
             bus.out_in};
      chk("controls", act, w.ctl);
      chk("step", 15'(bus.step), 15'(w.step));
      chk("halted", 15'(bus.halted), 15'(w.halted));
      chk("bus_single_driver", 15'($countones(act & DRIVERS) <= 1), 15'd1);
    end
  end

  initial begin
    bus.run = 1'b1; bus.opcode = 4'h0; bus.alu_carry = 1'b0; bus.alu_zero = 1'b0;
    // reset held with run=1: all strobes zero
    repeat (3) cyc(1, 1);
    // LDI, ADD, SUB back to back
    plan = '{4'h5, 4'h2, 4'h3};
    repeat (13) cyc(1, 0);
    // idle with run low
    repeat (10) cyc(0, 0);
    // LDA with run dropped after T0: completes, then idles
    plan = '{4'h1};
    cyc(1, 0);
    repeat (6) cyc(0, 0);
    // halt, stay halted with run high, reset recovers
    plan = '{4'hF};
    repeat (23) cyc(1, 0);
    cyc(1, 1);
    plan = '{4'h0};
    repeat (4) cyc(1, 0);
    // reset asserted at ADD T3
    plan = '{4'h2};
    repeat (3) cyc(1, 0);
    cyc(1, 1);
    repeat (3) cyc(1, 0);
    // flag ops: SUB latching zero=1 carry=0, then JZ and JC
    cyc(1, 1);
    fix_alu = 1; fix_c = 0; fix_z = 1;
    plan = '{4'h3, 4'h8, 4'h7};
    repeat (11) cyc(1, 0);
    fix_alu = 0;
    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);
    @(negedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
